// File: rtl/buffer_2d_loader_pkg.sv
// Shared constants for the window buffer path (loader, buffer, MAC).
//   - loader FSM state encoding
//   - default window edge length, pixel width and window-counter width
//   - pos_width(): bit width needed for a row/col index over n positions
package buffer_2d_loader_pkg;

    localparam int unsigned FILTER_SIZE_DEF      = 3;
    localparam int unsigned FILTER_BIT_WIDTH_DEF = 3;
    localparam int unsigned CNT_WIDTH_DEF        = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        FULL  = 2'd3
    } loader_state_e;

    // Index width for n positions, never narrower than one bit.
    function automatic int unsigned pos_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/buffer_2d_loader_if.sv
// Pixel stream, buffer write port and window handshake of the loader.
//   master: the loader (drives in_ready, buf_*, win_valid)
//   slave : the environment (drives in_valid, in_data, win_ready)
interface buffer_2d_loader_if
    import buffer_2d_loader_pkg::*;
#(
    parameter int unsigned filterSize     = FILTER_SIZE_DEF,
    parameter int unsigned filterBitWidth = FILTER_BIT_WIDTH_DEF
) ();

    logic                             in_valid;
    logic signed [filterBitWidth-1:0] in_data;
    logic                             in_ready;
    logic                             buf_en;
    logic        [filterSize-1:0]     buf_line_select;
    logic signed [filterBitWidth-1:0] buf_d_in;
    logic                             win_valid;
    logic                             win_ready;

    modport master (
        input  in_valid, in_data, win_ready,
        output in_ready, buf_en, buf_line_select, buf_d_in, win_valid
    );

    modport slave (
        output in_valid, in_data, win_ready,
        input  in_ready, buf_en, buf_line_select, buf_d_in, win_valid
    );

endinterface

// File: rtl/buffer_2d_loader_pos_counter.sv
// Row/column position of the next pixel inside the window.
//   clk, rst : clock, async active-low reset
//   clear    : synchronous return to row=col=0 (wins over inc)
//   inc      : one pixel accepted
//   row      : buffer line the next pixel goes to
//   last_c   : next pixel is the final one of the window (combinational)
module loader_pos_counter
    import buffer_2d_loader_pkg::*;
#(
    parameter  int unsigned filterSize = FILTER_SIZE_DEF,
    localparam int unsigned POS_W      = pos_width(filterSize)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [POS_W-1:0] row,
    output logic             last_c
);

    localparam logic [POS_W-1:0] LAST = POS_W'(filterSize - 1);

    logic [POS_W-1:0] col;

    assign last_c = (row == LAST) && (col == LAST);

    // Column wraps into the next row; the row wraps after the last pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col == LAST) begin
                col <= '0;
                row <= (row == LAST) ? '0 : row + POS_W'(1);
            end else begin
                col <= col + POS_W'(1);
            end
        end
    end

endmodule

// File: rtl/buffer_2d_loader.sv
// Window buffer write controller: steers a valid/ready pixel stream into the
// filterSize x filterSize buffer line by line and offers the full window to
// the MAC, stalling the stream until the window is taken.
//   clk, rst  : clock, async active-low reset
//   clear     : synchronous abort, restarts loading from pixel 0
//   bus       : pixel stream, buffer write port, window handshake (master)
//   busy      : state is not IDLE
//   win_count : windows handed to the consumer since reset (wraps)
module buffer_2d_loader
    import buffer_2d_loader_pkg::*;
#(
    parameter int unsigned filterSize     = FILTER_SIZE_DEF,
    parameter int unsigned filterBitWidth = FILTER_BIT_WIDTH_DEF,
    parameter int unsigned cntWidth       = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    buffer_2d_loader_if.master    bus,
    output logic                  busy,
    output logic [cntWidth-1:0]   win_count
);

    localparam int unsigned POS_W = pos_width(filterSize);

    loader_state_e                    state;
    logic        [POS_W-1:0]          row;
    logic                             last_c;
    logic                             abort;
    logic                             transfer;
    logic                             handshake;
    logic                             buf_en_q;
    logic        [filterSize-1:0]     sel_q;
    logic signed [filterBitWidth-1:0] d_in_q;

    // Clear outranks both a pixel transfer and the window handshake.
    assign abort     = clear && (state != IDLE);
    assign transfer  = bus.in_valid && (state == LOAD);
    assign handshake = bus.win_ready && (state == FULL);

    loader_pos_counter #(
        .filterSize (filterSize)
    ) u_pos (
        .clk    (clk),
        .rst    (rst),
        .clear  (abort || handshake),
        .inc    (transfer && !abort),
        .row    (row),
        .last_c (last_c)
    );

    // Handshake outputs decode straight from the state register.
    assign bus.in_ready        = (state == LOAD);
    assign bus.win_valid       = (state == FULL);
    assign bus.buf_en          = buf_en_q;
    assign bus.buf_line_select = sel_q;
    assign bus.buf_d_in        = d_in_q;
    assign busy                = (state != IDLE);

    // FSM plus buffer write port; select and data hold between writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            buf_en_q  <= 1'b0;
            sel_q     <= '0;
            d_in_q    <= '0;
            win_count <= '0;
        end else begin
            buf_en_q <= 1'b0;
            if (abort) begin
                state <= LOAD;
            end else begin
                case (state)
                    IDLE: state <= LOAD;
                    LOAD: begin
                        if (transfer) begin
                            buf_en_q <= 1'b1;
                            sel_q    <= filterSize'(1) << row;
                            d_in_q   <= bus.in_data;
                            if (last_c) begin
                                state <= DRAIN;
                            end
                        end
                    end
                    // Lets the final buffer write land before the window is offered.
                    DRAIN: state <= FULL;
                    FULL: begin
                        if (handshake) begin
                            state     <= LOAD;
                            win_count <= win_count + cntWidth'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_buffer_2d_loader.sv
// Self-checking bench for buffer_2d_loader: scoreboard of expected buffer
// writes filled when a pixel is offered to a ready loader, drained on buf_en.
module tb_buffer_2d_loader;

    localparam int unsigned FS = 3;
    localparam int unsigned BW = 3;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic [FS-1:0] sel;
        logic [BW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          busy;
    logic [CW-1:0] win_count;

    buffer_2d_loader_if #(.filterSize(FS), .filterBitWidth(BW)) bus ();

    buffer_2d_loader #(
        .filterSize     (FS),
        .filterBitWidth (BW),
        .cntWidth       (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .bus       (bus),
        .busy      (busy),
        .win_count (win_count)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   en_pulses = 0;
    int   exp_count = 0;
    int   pix_tbl[9] = '{1, 2, 3, -1, -2, -3, 0, 1, -4};

    // Every buffer write must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (bus.buf_en === 1'b1) begin
            exp_t e;
            en_pulses++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL buf_write_unexpected: sel=%b data=%b, no write expected",
                         bus.buf_line_select, bus.buf_d_in);
            end else begin
                e = q.pop_front();
                if (bus.buf_line_select !== e.sel || bus.buf_d_in !== e.data) begin
                    errors++;
                    $display("FAIL buf_write: sel=%b data=%b, expected sel=%b data=%b",
                             bus.buf_line_select, bus.buf_d_in, e.sel, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Offer one pixel; when the loader is ready the write is expected.
    task automatic send_pixel(input int idx, input int pix);
        int   n = 0;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_data  = BW'(pix);
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, expected 1", bus.in_ready, n);
        end else begin
            e.sel  = FS'(1 << (idx / FS));
            e.data = BW'(pix);
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    // Load a full window and check DRAIN then win_valid rising.
    task automatic load_window(input int off, input bit bubbles);
        en_pulses = 0;
        for (int i = 0; i < 9; i++) begin
            send_pixel(i, pix_tbl[(i + off) % 9]);
            if (bubbles && i < 8) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.win_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain: win_valid=%b in_ready=%b, expected 0 0", bus.win_valid, bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.win_valid !== 1'b1) begin
            errors++;
            $display("FAIL win_valid_rise: win_valid=%b, expected 1", bus.win_valid);
        end
        checks++;
        if (en_pulses != 9) begin
            errors++;
            $display("FAIL buf_en_pulses: got %0d, expected 9", en_pulses);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL writes_missing: %0d outstanding, expected 0", q.size());
        end
    endtask

    task automatic accept_window();
        bus.win_ready = 1'b1;
        @(negedge clk);
        bus.win_ready = 1'b0;
        exp_count = (exp_count + 1) % (1 << CW);
        checks++;
        if (win_count !== CW'(exp_count)) begin
            errors++;
            $display("FAIL win_count: got %0d, expected %0d", win_count, exp_count);
        end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.win_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_accept: in_ready=%b win_valid=%b, expected 1 0",
                     bus.in_ready, bus.win_valid);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.buf_en !== 1'b0 || bus.buf_line_select !== '0 ||
            bus.buf_d_in !== '0 || bus.win_valid !== 1'b0 || win_count !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b en=%b sel=%b d=%b wv=%b cnt=%0d busy=%b, expected all 0",
                     bus.in_ready, bus.buf_en, bus.buf_line_select, bus.buf_d_in,
                     bus.win_valid, win_count, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_release: in_ready=%b busy=%b, expected 0 0", bus.in_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_after_release: in_ready=%b busy=%b, expected 1 1", bus.in_ready, busy);
        end
    endtask

    task automatic test_stream();
        load_window(0, 1'b0);
    endtask

    task automatic test_hold();
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (bus.win_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.buf_en !== 1'b0) begin
                errors++;
                $display("FAIL hold_full: cycle %0d wv=%b rdy=%b en=%b, expected 1 0 0",
                         c, bus.win_valid, bus.in_ready, bus.buf_en);
            end
        end
        bus.in_valid = 1'b0;
        accept_window();
    endtask

    task automatic test_bubbles();
        load_window(3, 1'b1);
        accept_window();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) begin
            send_pixel(i, pix_tbl[i]);
        end
        // A pixel offered alongside clear must not be written.
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = BW'(2);
        @(negedge clk);
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.buf_en !== 1'b0 || bus.in_ready !== 1'b1 || win_count !== CW'(exp_count)) begin
            errors++;
            $display("FAIL clear_mid_load: en=%b rdy=%b cnt=%0d, expected 0 1 %0d",
                     bus.buf_en, bus.in_ready, win_count, exp_count);
        end
        load_window(5, 1'b0);
        // Clear beats a simultaneous window handshake.
        clear         = 1'b1;
        bus.win_ready = 1'b1;
        @(negedge clk);
        clear         = 1'b0;
        bus.win_ready = 1'b0;
        checks++;
        if (bus.win_valid !== 1'b0 || bus.in_ready !== 1'b1 || win_count !== CW'(exp_count)) begin
            errors++;
            $display("FAIL clear_in_full: wv=%b rdy=%b cnt=%0d, expected 0 1 %0d",
                     bus.win_valid, bus.in_ready, win_count, exp_count);
        end
        load_window(2, 1'b0);
        accept_window();
    endtask

    task automatic test_reset_full();
        while (exp_count != 3) begin
            load_window(4, 1'b0);
            accept_window();
        end
        load_window(7, 1'b0);
        checks++;
        if (win_count !== CW'(3)) begin
            errors++;
            $display("FAIL count_before_reset: got %0d, expected 3", win_count);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.win_valid !== 1'b0 || win_count !== '0 || bus.in_ready !== 1'b0 ||
            bus.buf_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: wv=%b cnt=%0d rdy=%b en=%b busy=%b, expected all 0",
                     bus.win_valid, win_count, bus.in_ready, bus.buf_en, busy);
        end
        exp_count = 0;
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_rerelease: busy=%b, expected 0", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_after_rerelease: busy=%b rdy=%b, expected 1 1", busy, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int w = 0; w < (1 << CW); w++) begin
            load_window(w % 9, 1'b0);
            accept_window();
        end
        checks++;
        if (win_count !== '0) begin
            errors++;
            $display("FAIL count_wrap: got %0d, expected 0", win_count);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.win_ready = 1'b0;
        test_reset();
        test_stream();
        test_hold();
        test_bubbles();
        test_clear();
        test_reset_full();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/buffer_2d_loader.md
Name: buffer_2d_loader

Overview:
Upstream write controller for the filterSize x filterSize window buffer. It accepts a valid/ready pixel stream and steers each pixel into the correct buffer line through a one-hot line select and write enable. It tracks row and column position, and presents a complete window to the downstream consumer (the MAC) with a valid/ready handshake. It stalls the input stream until the consumer takes the window, then reloads.

Parameters:
filterSize, 3, window edge length; number of buffer lines and pixels per line
filterBitWidth, 3, signed pixel width in bits
cntWidth, 16, width of the delivered-window counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous, active-low
clear  input  1  synchronous abort; restarts window loading
in_valid  input  1  upstream pixel valid
in_data  input  filterBitWidth  signed pixel
in_ready  output  1  controller accepts a pixel this cycle
buf_en  output  1  buffer write enable, registered
buf_line_select  output  filterSize  one-hot line select, registered
buf_d_in  output  filterBitWidth  pixel to buffer, registered
win_valid  output  1  buffer holds a complete window
win_ready  input  1  consumer accepts the window
busy  output  1  high whenever state is not IDLE
win_count  output  cntWidth  windows delivered since reset; wraps

Behaviour:
- Reset (rst=0, async):
  - State IDLE; row=col=0.
  - in_ready=0, buf_en=0, buf_line_select=0, buf_d_in=0, win_valid=0, win_count=0.
- States and transitions:
  - IDLE -> LOAD unconditionally on the first clk after reset release.
  - LOAD: in_ready=1. A transfer occurs when in_valid&in_ready.
  - LOAD -> DRAIN on the transfer of the last pixel (row=col=filterSize-1).
  - DRAIN -> FULL after one cycle. In DRAIN, in_ready=0.
  - FULL: win_valid=1, in_ready=0. Hold until win_valid&win_ready.
  - FULL -> LOAD on win_valid&win_ready: row=col=0, win_count+1.
- in_ready and win_valid are registered (decoded from the state register); they carry no combinational path from inputs.
- Transfer at edge k:
  - At edge k: buf_en<=1, buf_line_select<=(1<<row), buf_d_in<=in_data.
  - The buffer captures the pixel at edge k+1.
  - Without a transfer, buf_en<=0. buf_line_select and buf_d_in hold their previous values.
- Counters:
  - col increments per transfer and wraps at filterSize-1 to 0, which also increments row.
  - row never exceeds filterSize-1.
  - Pixels fill line 0 first, then line 1, and so on.
- Latency: last pixel transfer at edge k -> final buffer write at edge k+1 -> win_valid=1 after edge k+1 (DRAIN occupies the cycle between).
- Back-pressure:
  - in_valid=0 in LOAD inserts bubbles; counters hold.
  - win_ready=0 holds FULL indefinitely; buffer contents are untouched (buf_en=0).
- clear=1 (any state except IDLE):
  - Next edge: state LOAD, row=col=0, buf_en=0, win_valid=0.
  - win_count is unchanged.
  - clear has priority over a simultaneous transfer or window handshake; neither takes effect.
- Reset mid-load or mid-FULL: the partial window is discarded and the outputs return to reset values immediately.
- win_count wraps from 2^cntWidth-1 to 0.
- No arithmetic is performed on pixel data; the sign is preserved bit-exact.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, LOAD=2'd1, DRAIN=2'd2, FULL=2'd3.
  - Default filterSize and filterBitWidth constants, shared with the buffer and MAC.
- One natural sub-module, loader_pos_counter: row/col counter with wrap, clear and a last-pixel flag.
- FSM and output registers stay in buffer_2d_loader.

Test Plan:
- Reset release, in_valid held 1, pixels 1,2,3,-1,-2,-3,0,1,-4 (defaults):
  - in_ready rises one cycle after release.
  - buf_line_select reads 001,001,001,010,010,010,100,100,100, each one cycle after its transfer.
  - win_valid rises 2 cycles after the 9th transfer.
- Window held with win_ready=0 for 10 cycles:
  - win_valid stays 1, in_ready stays 0, buf_en stays 0.
  - win_ready=1 -> win_count=1; in_ready=1 on the next cycle.
- in_valid toggles 1,0,1,0 during LOAD:
  - Exactly 9 buf_en pulses, with select sequence as in scenario 1.
  - win_valid rises only after the 9th accepted pixel.
- clear asserted after 5 transfers:
  - Next cycle row=col=0, buf_en=0.
  - The following 9 pixels load lines 0..2 from the start; win_count unchanged.
- rst pulsed low while in FULL with win_count=3:
  - win_valid=0 and win_count=0 immediately, without waiting for a clk edge.
  - IDLE then LOAD after release.
- 2^16 windows delivered with cntWidth=16: win_count wraps to 0.
